// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the LSU data_memory master.
//   lsu_size_t  : access size encoding carried on req_size
//   lsu_state_t : master FSM states (exposed on dbg_state)
//   STAT_W      : width of the optional statistics counters
//   sat_inc     : saturating increment used by the statistics counters
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic shared by the load and read-modify-write
// paths of lsu_mem_master.
//   rdata      in  : word returned by data_memory
//   wdata      in  : right-aligned store data
//   size       in  : lsu_size_t access size
//   lane       in  : byte lane (byte address bits [1:0])
//   sgn        in  : sign-extend sub-word load results
//   load_data  out : selected lane(s) of rdata, sign/zero extended
//   merge_data out : rdata with the selected lane(s) replaced by wdata
//   misaligned out : access cannot be performed (bad alignment or reserved size)
module lsu_align
    import lsu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rdata,
    input  logic [W-1:0] wdata,
    input  logic [1:0]   size,
    input  logic [1:0]   lane,
    input  logic         sgn,
    output logic [W-1:0] load_data,
    output logic [W-1:0] merge_data,
    output logic         misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{lane, 3'b000} +: 8];
        half_v     = rdata[{lane[1], 4'b0000} +: 16];
        load_data  = '0;
        merge_data = rdata;
        misaligned = 1'b0;
        case (lsu_size_t'(size))
            SZ_BYTE: begin
                load_data = {{(W-8){sgn & byte_v[7]}}, byte_v};
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                // lane[1] picks the half; lane[0] set means the half straddles lanes.
                load_data  = {{(W-16){sgn & half_v[15]}}, half_v};
                merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                misaligned = lane[0];
            end
            SZ_WORD: begin
                load_data  = rdata;
                merge_data = wdata;
                misaligned = (lane != 2'd0);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: initiator side of the data_memory port. Accepts byte/half/word
// load and store requests, drives data_memory, and returns aligned, extended
// load data. data_memory has no byte enables, so sub-word stores are done as
// read-modify-write (READ -> MERGE -> WRITE).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake
//   req_we, req_size,
//   req_signed, req_addr,
//   req_wdata                request fields (byte address, right-aligned data)
//   rsp_valid                one-cycle response pulse
//   rsp_rdata                load result (0 for stores), held until next response
//   rsp_err                  misaligned/reserved request, no memory access made
//   address, MemRead,
//   MemWrite, write_data     to data_memory
//   read_data                from data_memory, valid RD_LAT cycles after MemRead
//   dbg_state                current FSM state (lsu_state_t encoding)
//
// Optional feature: define LSU_STATS_EN to add saturating counters
// stat_loads, stat_stores, stat_errs (STAT_W bits each).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so at most one request is outstanding; all
// request fields are captured on transfer and req_valid is ignored afterwards.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 5,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [N+1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [N-1:0] address,
    output logic         MemRead,
    output logic         MemWrite,
    output logic [W-1:0] write_data,
    input  logic [W-1:0] read_data,
    output logic [2:0]   dbg_state
`ifdef LSU_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic          sgn_q;
    lsu_size_t     size_q;
    logic [1:0]    lane_q;
    logic [N-1:0]  idx_q;
    logic [W-1:0]  wbuf_q;   // store data, later the merged word
    logic          err_q;
    logic [W-1:0]  rdata_q;  // last response data, held between responses

    logic          accept;
    logic          read_done;
    logic [1:0]    sel_size;
    logic [1:0]    sel_lane;
    logic [W-1:0]  load_data;
    logic [W-1:0]  merge_data;
    logic          misaligned;

    assign accept    = req_valid && (state_q == IDLE);
    assign read_done = (cnt_q == CW'(RD_LAT - 1));

    // In IDLE the aligner checks the incoming request; afterwards it works on
    // the captured request for extraction and merging.
    assign sel_size = (state_q == IDLE) ? req_size      : size_q;
    assign sel_lane = (state_q == IDLE) ? req_addr[1:0] : lane_q;

    lsu_align #(.W(W)) u_align (
        .rdata      (read_data),
        .wdata      (wbuf_q),
        .size       (sel_size),
        .lane       (sel_lane),
        .sgn        (sgn_q),
        .load_data  (load_data),
        .merge_data (merge_data),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            lane_q  <= '0;
            idx_q   <= '0;
            wbuf_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == READ) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (accept) begin
                we_q   <= req_we;
                sgn_q  <= req_signed;
                size_q <= lsu_size_t'(req_size);
                lane_q <= req_addr[1:0];
                idx_q  <= req_addr[N+1:2];
                wbuf_q <= req_wdata;
                err_q  <= misaligned;
            end
            // read_data is valid during MERGE; fold the new lanes in here.
            if (state_q == MERGE) begin
                wbuf_q <= merge_data;
            end
            if (state_q == RESP) begin
                rdata_q <= rsp_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = RESP;
                    end else if (req_we && (lsu_size_t'(req_size) == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (read_done) begin
                    state_d = we_q ? MERGE : RESP;
                end
            end
            MERGE:   state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        MemRead    = (state_q == READ);
        MemWrite   = (state_q == WRITE);
        rsp_valid  = (state_q == RESP);
        rsp_err    = (state_q == RESP) && err_q;
        address    = '0;
        write_data = '0;
        if ((state_q == READ) || (state_q == MERGE) || (state_q == WRITE)) begin
            address = idx_q;
        end
        if (state_q == WRITE) begin
            write_data = wbuf_q;
        end
        // For loads read_data is still valid in RESP, so the result is taken
        // straight from the aligner; errors leave the previous result in place.
        rsp_rdata = rdata_q;
        if ((state_q == RESP) && !err_q) begin
            rsp_rdata = we_q ? '0 : load_data;
        end
    end

    assign dbg_state = state_q;

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (state_q == RESP) begin
            if (err_q) begin
                stat_errs <= sat_inc(stat_errs);
            end else if (we_q) begin
                stat_stores <= sat_inc(stat_stores);
            end else begin
                stat_loads <= sat_inc(stat_loads);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int W      = 32;
  localparam int N      = 5;
  localparam int RD_LAT = 2;
  localparam int NW     = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [1:0]   req_size = 2'd0;
  logic         req_signed = 1'b0;
  logic [N+1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;
  logic [N-1:0] address;
  logic         MemRead;
  logic         MemWrite;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;
  logic [2:0]   dbg_state;
`ifdef LSU_STATS_EN
  logic [STAT_W-1:0] stat_loads, stat_stores, stat_errs;
`endif

  lsu_mem_master #(.W(W), .N(N), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .address    (address),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .write_data (write_data),
    .read_data  (read_data),
    .dbg_state  (dbg_state)
`ifdef LSU_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // ---------------- data_memory environment ----------------
  // Synchronous memory: data appears RD_LAT edges after MemRead; a read
  // without MemRead returns a poison pattern.
  logic [W-1:0] mem [NW];
  logic [W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (MemWrite) mem[address] <= write_data;
    pipe[0] <= MemRead ? mem[address] : 32'hDEAD_0BAD;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign read_data = pipe[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] ref_mem [NW];
  logic [W-1:0] last_rsp = '0;
  logic [W-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observations of one transaction.
  int           o_lat, o_rd, o_wr, o_both;
  logic         o_got, o_err, o_ready_after;
  logic [W-1:0] o_rdata, o_waddr, o_wdata;

  // ---------------- driver ----------------
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [6:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    // Scramble the request bus: the captured request must be used.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 7'($urandom);
    req_wdata  = $urandom;
    o_lat = 0; o_rd = 0; o_wr = 0; o_both = 0;
    o_got = 1'b0; o_err = 1'b0; o_ready_after = 1'b0;
    o_rdata = '0; o_waddr = '0; o_wdata = '0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (MemRead) o_rd++;
      if (MemWrite) begin
        o_wr++;
        o_waddr = 32'(address);
        o_wdata = write_data;
      end
      if (MemRead && MemWrite) o_both++;
      if (rsp_valid) begin
        o_got   = 1'b1;
        o_lat   = k + 1;
        o_rdata = rsp_rdata;
        o_err   = rsp_err;
        break;
      end
    end
    if (o_got) begin
      @(posedge clk);
      #1;
      o_ready_after = req_ready;
    end
  endtask

  // Issue one request and compare it with the model's view of it.
  task automatic check_req(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [6:0] addr, input logic [31:0] wdata);
    int           idx, lane, sh, bits, exp_lat, exp_rd, exp_wr;
    logic         mis;
    logic [31:0]  mask, v, newv, exp_rsp;
    idx  = int'(addr) / 4;
    lane = int'(addr) % 4;
    sh   = lane * 8;
    bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 1);
    mis  = (size == 2'd3) || (size == 2'd1 && (lane % 2) != 0) || (size == 2'd2 && lane != 0);
    newv = ref_mem[idx];
    if (mis) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0; exp_rsp = last_rsp;
    end else if (we) begin
      newv    = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
      exp_lat = (size == 2'd2) ? 2 : RD_LAT + 3;
      exp_rd  = (size == 2'd2) ? 0 : RD_LAT;
      exp_wr  = 1;
      exp_rsp = '0;
    end else begin
      v = (ref_mem[idx] >> sh) & mask;
      if (sgn && bits < 32 && ((v >> (bits - 1)) & 32'd1) == 32'd1) v = v | ~mask;
      exp_lat = RD_LAT + 1; exp_rd = RD_LAT; exp_wr = 0; exp_rsp = v;
    end
    exp_q.push_back(exp_rsp);
    run_req(we, size, sgn, addr, wdata);
    chk({tag, ".got_rsp"}, 32'(o_got), 32'd1);
    chk({tag, ".latency"}, 32'(o_lat), 32'(exp_lat));
    chk({tag, ".rsp_rdata"}, o_rdata, exp_q.pop_front());
    chk({tag, ".rsp_err"}, 32'(o_err), 32'(mis));
    chk({tag, ".memread_cycles"}, 32'(o_rd), 32'(exp_rd));
    chk({tag, ".memwrite_cycles"}, 32'(o_wr), 32'(exp_wr));
    chk({tag, ".rd_wr_overlap"}, 32'(o_both), 32'd0);
    chk({tag, ".ready_after"}, 32'(o_ready_after), 32'd1);
    if (we && !mis) begin
      chk({tag, ".wr_address"}, o_waddr, 32'(idx));
      chk({tag, ".wr_data"}, o_wdata, newv);
    end
    ref_mem[idx] = newv;
    last_rsp     = exp_rsp;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rnd;
    int found, wr_seen;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.MemRead", 32'(MemRead), 32'd0);
    chk("reset.MemWrite", 32'(MemWrite), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.address", 32'(address), 32'd0);
    chk("reset.write_data", write_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill every word with random data, then read all of them back.
    for (int i = 0; i < NW; i++) begin
      rnd = $urandom;
      check_req("fill", 1'b1, 2'd2, 1'b0, 7'(i * 4), rnd);
    end
    for (int i = NW - 1; i >= 0; i--) begin
      check_req("readback", 1'b0, 2'd2, 1'($urandom), 7'(i * 4), 32'd0);
    end
    // Last word, top lane, then word 0: no carry into a neighbouring word.
    check_req("wrap_store", 1'b1, 2'd0, 1'b0, 7'h7F, 32'h0000_00A5);
    check_req("wrap_load31", 1'b0, 2'd2, 1'b0, 7'h7C, 32'd0);
    check_req("wrap_load0", 1'b0, 2'd2, 1'b0, 7'h00, 32'd0);

    // Word store / word load
    check_req("wst08", 1'b1, 2'd2, 1'b0, 7'h08, 32'hDEAD_BEEF);
    chk("wst08.literal_wdata", o_wdata, 32'hDEAD_BEEF);
    chk("wst08.literal_addr", o_waddr, 32'd2);
    check_req("wld08", 1'b0, 2'd2, 1'b0, 7'h08, 32'd0);
    chk("wld08.literal", o_rdata, 32'hDEAD_BEEF);

    // Byte RMW store
    check_req("pre_rmw", 1'b1, 2'd2, 1'b0, 7'h08, 32'h1122_3344);
    check_req("bst09", 1'b1, 2'd0, 1'b0, 7'h09, 32'h0000_005A);
    chk("bst09.literal_wdata", o_wdata, 32'h1122_5A44);

    // Signed / unsigned byte loads
    check_req("pre_bld", 1'b1, 2'd2, 1'b0, 7'h08, 32'h80FF_7F01);
    check_req("bld0b_s", 1'b0, 2'd0, 1'b1, 7'h0B, 32'd0);
    chk("bld0b_s.literal", o_rdata, 32'hFFFF_FF80);
    check_req("bld0b_u", 1'b0, 2'd0, 1'b0, 7'h0B, 32'd0);
    chk("bld0b_u.literal", o_rdata, 32'h0000_0080);

    // Half loads, aligned and misaligned
    check_req("pre_hld", 1'b1, 2'd2, 1'b0, 7'h0C, 32'h8001_ABCD);
    check_req("hld0e_s", 1'b0, 2'd1, 1'b1, 7'h0E, 32'd0);
    chk("hld0e_s.literal", o_rdata, 32'hFFFF_8001);
    check_req("hld0d_err", 1'b0, 2'd1, 1'b1, 7'h0D, 32'd0);
    chk("hld0d_err.literal_hold", o_rdata, 32'hFFFF_8001);
    check_req("rsvd_err", 1'b1, 2'd3, 1'b0, 7'h10, 32'h1234_5678);
    check_req("wmis_err", 1'b1, 2'd2, 1'b0, 7'h12, 32'h1234_5678);

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      check_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                7'($urandom_range(0, 127)), $urandom);
    end

    // Reset asserted during MERGE of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 7'h15; req_wdata = 32'h0000_00C3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (dbg_state == MERGE) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rst_merge.reached", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_merge.MemWrite", 32'(MemWrite), 32'd0);
    chk("rst_merge.req_ready", 32'(req_ready), 32'd1);
    chk("rst_merge.address", 32'(address), 32'd0);
    chk("rst_merge.rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (MemWrite) wr_seen++;
    end
    chk("rst_merge.no_write", 32'(wr_seen), 32'd0);
    chk("rst_merge.ready_after", 32'(req_ready), 32'd1);
    last_rsp = '0;
    check_req("rst_merge.word_intact", 1'b0, 2'd2, 1'b0, 7'h14, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the data_memory port.
- Accepts byte, half and word load/store requests from the core pipeline over a valid/ready handshake.
- Drives address, MemRead, MemWrite and write_data into data_memory, then returns aligned, sign- or zero-extended load data.
- data_memory has no byte enables, so sub-word stores run as read-modify-write.

Parameters:
- W, 32, data word width in bits (multiple of 16).
- N, 5, data_memory word-address width; byte address width is N+2.
- RD_LAT, 1, cycles from MemRead+address asserted to read_data valid (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_we  in  1  1=store, 0=load
- req_size  in  2  lsu_size_t: 0=byte, 1=half, 2=word, 3=reserved
- req_signed  in  1  sign-extend load result
- req_addr  in  N+2  byte address
- req_wdata  in  W  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  W  load result (0 for stores)
- rsp_err  out  1  misaligned or reserved size; no memory access performed
- address  out  N  to data_memory
- MemRead  out  1  to data_memory
- MemWrite  out  1  to data_memory
- write_data  out  W  to data_memory
- read_data  in  W  from data_memory

Behaviour:
- Reset (rst=0, async): state IDLE.
  - req_ready=1.
  - rsp_valid, rsp_err, MemRead, MemWrite = 0.
  - rsp_rdata, address, write_data = 0.
  - Latency counter = 0.
- Handshake: request accepted when req_valid && req_ready at posedge. Request fields captured into registers. req_ready=1 only in IDLE; one outstanding request.
- Word index = req_addr[N+1:2]; byte lane = req_addr[1:0].
- Misaligned cases:
  - half with lane[0]=1
  - word with lane≠0
  - size=3
  - Result: IDLE→RESP with rsp_err=1, no MemRead/MemWrite pulse.
- FSM:
  - IDLE: on accept →
    - ERR-check.
    - Word store: WRITE.
    - Load or sub-word store: READ.
  - READ: MemRead=1, address held; count RD_LAT cycles.
    - Load → RESP.
    - Sub-word store → MERGE.
  - MERGE: read_data captured; selected lane(s) replaced by low bits of req_wdata; other bytes preserved → WRITE.
  - WRITE: MemWrite=1 for exactly one cycle with address/write_data → RESP.
  - RESP: rsp_valid=1 one cycle → IDLE. req_ready returns 1 the following cycle.
- Load extract:
  - Byte = read_data[8*lane +: 8].
  - Half = read_data[16*lane[1] +: 16].
  - Sign-extend if req_signed, else zero-extend; ignored for word.
- Latencies (accept to rsp_valid):
  - Word store: 2 cycles.
  - Load: RD_LAT+1.
  - Sub-word store: RD_LAT+3.
  - Error: 1.
- MemRead and MemWrite never high in the same cycle.
- address wraps naturally within 2^N words; no bounds error.
- req_valid dropped mid-operation has no effect; captured request completes.
- Reset mid-operation: immediate abort, outputs to reset values, no partial write completes after rst deasserts.
- rsp_rdata holds last value until next response.

Optional Feature:
- LSU_STATS_EN defined:
  - Adds outputs stat_loads, stat_stores, stat_errs, each 16 bits, saturating, reset to 0.
  - Incremented on the RESP cycle of the matching type; errors count only in stat_errs.
- Not defined: ports and counters absent; all other behaviour identical.

Decomposition:
- lsu_pkg:
  - lsu_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD).
  - lsu_state_t enum (IDLE, READ, MERGE, WRITE, RESP).
  - Constant STAT_W=16.
- Sub-module lsu_align, purely combinational:
  - Load extract/extend.
  - Store lane merge.
  - Misalignment check.
  - Shared by load and RMW paths.

Test Plan:
- Word store addr 0x08 data 0xDEADBEEF, then word load addr 0x08:
  - Store: MemWrite one pulse, address=2, write_data=0xDEADBEEF.
  - Load: rsp_rdata=0xDEADBEEF after RD_LAT+1 cycles.
- Byte store 0x5A to addr 0x09 over word 0x11223344:
  - MemRead pulse, then MemWrite with write_data=0x11225A44.
  - rsp_valid RD_LAT+3 cycles after accept.
- Signed byte load addr 0x0B on word 0x80FF7F01: rsp_rdata=0xFFFFFF80. Unsigned same address: 0x00000080.
- Half load addr 0x0E on word 0x8001ABCD:
  - signed → 0xFFFF8001.
  - Half load addr 0x0D → rsp_err=1, no MemRead/MemWrite, rsp_rdata unchanged.
- Fill all 32 words with random data via word stores, read back every address: each matches. address wraps 31→0 correctly.
- Assert rst=0 during MERGE of a byte store: no MemWrite pulse occurs, target word unchanged, req_ready=1 after rst releases.
